segment_scan_controller: RTL
============================

// Module: segment_scan_controller
// PURPOSE
//  Time-multiplexes DIGITS hex digits onto one shared segment_decoder and one
//  common-anode 7-segment bus. Selects one digit per slot, drives its BCD nibble
//  to the decoder and gates the decoder's active-low segments back out.
//  Inserts an all-off guard interval before each slot to suppress ghosting.
//  Provides tear-free frame-synchronous updates and leading-zero blanking.
// PARAMETERS
//  DIGITS        4      number of multiplexed digits; minimum 2
//  CLK_DIV       50000  clk cycles per digit slot, guard included; > BLANK_CYCLES
//  BLANK_CYCLES  16     guard cycles at the start of each slot; minimum 1
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  value_in   in   4*DIGITS   nibble i = digit i; digit 0 is least significant
//  dp_in      in   DIGITS     decimal point per digit, 1 = lit
//  load       in   1          1-cycle strobe: capture value_in/dp_in into pending
//  blank_lz   in   1          1 = blank leading zeros
//  bcd_out    out  4          registered nibble to segment_decoder.bcd
//  seg_in     in   7          segment_decoder.segment, active-low
//  seg_n      out  7          segments to pins, active-low
//  dp_n       out  1          decimal point to pins, active-low
//  an_n       out  DIGITS     digit enables, active-low, one-cold or all-high
//  frame_tick out  1          1-cycle pulse at each frame start
// BEHAVIOUR
//  Reset values: idx=0, cnt=0, state=GUARD, an_n all 1, dp_n=1, bcd_out=0,
//   frame_tick=0, pending and display registers 0. While rst=1, seg_n=7'h7F.
//   rst mid-slot aborts the slot; the first cycle after rst starts GUARD of digit 0.
//  Counter cnt counts 0..CLK_DIV-1 per slot.
//   GUARD while cnt<BLANK_CYCLES; ON while cnt>=BLANK_CYCLES.
//  FSM GUARD->ON when cnt==BLANK_CYCLES-1.
//   ON->GUARD when cnt==CLK_DIV-1, with cnt<=0 and idx<=idx+1.
//   idx wraps DIGITS-1 -> 0.
//  Slot length is exactly CLK_DIV cycles. Frame length is exactly DIGITS*CLK_DIV.
//  an_n[idx]=0 exactly on the ON cycles of slot idx; all other bits stay 1.
//   All bits are 1 throughout GUARD.
//  bcd_out = display nibble idx. It is valid from the first GUARD cycle of the slot,
//   so the combinational decoder settles before ON.
//  seg_n = seg_in when ON and the digit is not blanked; otherwise seg_n=7'h7F.
//  dp_n = ~dp when ON; otherwise 1. dp is not affected by leading-zero blanking.
//  Leading-zero blanking: with blank_lz=1, digit i>0 is blanked when nibbles
//   DIGITS-1..i of display are all 0. Digit 0 is never blanked.
//   Evaluated on the display register.
//  load=1: pending <= {value_in, dp_in}. A later load overwrites an earlier one.
//  Frame boundary = the ON->GUARD transition with idx==DIGITS-1.
//   At that edge display <= pending, and frame_tick=1 for the following cycle
//   (the first GUARD cycle of digit 0).
//  load on the boundary cycle: pending takes the new value; display takes the
//   old pending. The new value is shown one frame later.
//  Display never changes mid-frame, so there is no tearing.
// TESTING
//  1 Reset/timing (DIGITS=4,CLK_DIV=8,BLANK=2): release rst.
//    -> an_n=1111 on cycles 0-1; an_n=1110 on 2-7; 1111 on 8-9; 1101 on 10-15.
//    -> frame_tick pulses on cycle 32.
//  2 Data path: load value_in=16'h1A3F, dp_in=4'b0100, blank_lz=0; wait 2 frames.
//    -> bcd_out=F,3,A,1 in slots 0..3.
//    -> dp_n=0 only during ON of digit 2.
//    -> seg_n equals seg_in only during ON cycles.
//  3 Leading zeros: load 16'h0050, blank_lz=1.
//    -> digits 3,2 show seg_n=7F; digits 1,0 show decoder 5 and 0.
//    Load 16'h0000 -> only digit 0 lit.
//  4 Tear-free update: load 16'h1234 mid-frame.
//    -> current frame unchanged; new value shown from the next frame_tick.
//    Load exactly on the boundary cycle -> shown one frame later.
//  5 Reset mid-slot: assert rst during ON of digit 2.
//    -> next cycle an_n=1111 and seg_n=7F; display=0.
//    -> restarts at GUARD of digit 0.
//  6 Ghosting: over a full frame, assert that no cycle has more than one an_n bit low.
//    -> an_n=all 1 on every GUARD cycle.

Source files
------------

// File: rtl/segment_scan_if.sv
// Bus between the digit-scan controller and its data source / segment decoder.
// The slave modport is the controller side.
interface segment_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                blank_lz;
  logic [3:0]          bcd_out;
  logic [6:0]          seg_in;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame_tick;

  modport master (
    output value_in, dp_in, load, blank_lz, seg_in,
    input  bcd_out, seg_n, dp_n, an_n, frame_tick
  );

  modport slave (
    input  value_in, dp_in, load, blank_lz, seg_in,
    output bcd_out, seg_n, dp_n, an_n, frame_tick
  );
endinterface

// File: rtl/segment_scan_controller.sv
// Multiplexes DIGITS hex digits onto one shared decoder and a common-anode 7-segment bus,
// with a blank guard before each slot, frame-synchronous updates and leading-zero blanking.
module segment_scan_controller #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  segment_scan_if.slave bus
);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned NW = 4 * DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {GUARD, ON} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [NW-1:0]     pend_val, disp_val, disp_val_nx;
  logic [DIGITS-1:0] pend_dp, disp_dp, disp_dp_nx;
  logic [3:0]        bcd_q, bcd_nx;
  logic              tick_q;
  logic              slot_end, frame_end;
  logic              blanked, cur_dp;
  logic [DIGITS-1:0] lead_zero, an_c;
  logic [6:0]        seg_c;
  logic              dp_c;

  always_ff @(posedge clk) begin
    if (rst) state <= GUARD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    slot_end = 1'b0;
    case (state)
      GUARD:   if (cnt == GUARD_LAST) state_nx = ON;
      ON:      if (cnt == CNT_LAST) begin
                 state_nx = GUARD;
                 slot_end = 1'b1;
               end
      default: state_nx = GUARD;
    endcase
    frame_end = slot_end && (idx == IDX_LAST);
    cnt_nx    = slot_end ? '0 : cnt + 1'b1;
    if (slot_end) idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    else          idx_nx = idx;
    disp_val_nx = frame_end ? pend_val : disp_val;
    disp_dp_nx  = frame_end ? pend_dp  : disp_dp;
  end

  // bcd_out is looked up from the next slot's digit so it is already stable on the
  // first guard cycle, giving the external decoder the whole guard to settle.
  always_comb begin
    bcd_nx    = '0;
    blanked   = 1'b0;
    cur_dp    = 1'b0;
    lead_zero = '0;
    an_c      = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lead_zero[i] = (i != 0) && ((disp_val >> (4 * i)) == '0);
      if (IW'(i) == idx_nx) bcd_nx = disp_val_nx[4*i +: 4];
      if (IW'(i) == idx) begin
        blanked = bus.blank_lz && lead_zero[i];
        cur_dp  = disp_dp[i];
        if (state == ON) an_c[i] = 1'b0;
      end
    end
    seg_c = (!rst && state == ON && !blanked) ? bus.seg_in : '1;
    dp_c  = (state == ON) ? ~cur_dp : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      bcd_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      disp_val <= disp_val_nx;
      disp_dp  <= disp_dp_nx;
      bcd_q    <= bcd_nx;
      tick_q   <= frame_end;
      if (bus.load) begin
        pend_val <= bus.value_in;
        pend_dp  <= bus.dp_in;
      end
    end
  end

  assign bus.bcd_out    = bcd_q;
  assign bus.frame_tick = tick_q;
  assign bus.an_n       = an_c;
  assign bus.seg_n      = seg_c;
  assign bus.dp_n       = dp_c;
endmodule
